// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the core's control decode and the program loader.
// Holds the opcode/funct values, the loader's operation codes and word-packing helpers.
package mips_isa_pkg;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_NOR = 6'b100111;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NOR  = 4'd5,
      OP_ADDI = 4'd6,
      OP_LW   = 4'd7,
      OP_SW   = 4'd8
   } op_e;

   function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [5:0] funct);
      return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
   endfunction

   function automatic logic [31:0] enc_i(logic [5:0] opc, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Instruction-beat stream into the loader: valid/ready handshake plus mnemonic fields.
interface instr_encoder_loader_if;

   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [15:0] in_imm;
   logic        in_last;

   modport master (
      output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last,
      output in_ready
   );

endinterface

// File: rtl/instr_encode.sv
// Combinational encoder: mnemonic fields to a 32-bit MIPS word, flagging unknown ops.
module instr_encode
   import mips_isa_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [4:0]  i_rs,
   input  logic [4:0]  i_rt,
   input  logic [4:0]  i_rd,
   input  logic [15:0] i_imm,
   output logic [31:0] o_word,
   output logic        o_illegal
);

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      o_word    = '0;
      o_illegal = 1'b0;
      case (i_op)
         OP_ADD:  o_word = enc_r(i_rs, i_rt, i_rd, FN_ADD);
         OP_SUB:  o_word = enc_r(i_rs, i_rt, i_rd, FN_SUB);
         OP_AND:  o_word = enc_r(i_rs, i_rt, i_rd, FN_AND);
         OP_OR:   o_word = enc_r(i_rs, i_rt, i_rd, FN_OR);
         OP_XOR:  o_word = enc_r(i_rs, i_rt, i_rd, FN_XOR);
         OP_NOR:  o_word = enc_r(i_rs, i_rt, i_rd, FN_NOR);
         OP_ADDI: o_word = enc_i(OPC_ADDI, i_rs, i_rt, i_imm);
         OP_LW:   o_word = enc_i(OPC_LW, i_rs, i_rt, i_imm);
         OP_SW:   o_word = enc_i(OPC_SW, i_rs, i_rt, i_imm);
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes streamed beats into consecutive instruction-memory words
// while holding the CPU in reset, then releases it once the program is complete.
module instr_encoder_loader
   import mips_isa_pkg::*;
#(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   instr_encoder_loader_if.slave    in_if,
   output logic                     imem_we,
   output logic [ADDR_WIDTH-1:0]    imem_addr,
   output logic [31:0]              imem_wdata,
   output logic                     cpu_hold,
   output logic                     done,
   output logic                     err,
   output logic [ADDR_WIDTH:0]      count
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_e;

   localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

   state_e                r_state, w_next;
   logic                  r_ready, r_we, r_err;
   logic [ADDR_WIDTH-1:0] r_ptr, r_addr;
   logic [31:0]           r_wdata;
   logic [ADDR_WIDTH:0]   r_count;

   logic [31:0] w_word;
   logic        w_illegal, w_accept, w_write, w_full, w_end, w_start;

   instr_encode u_encode (
      .i_op      (in_if.in_op),
      .i_rs      (in_if.in_rs),
      .i_rt      (in_if.in_rt),
      .i_rd      (in_if.in_rd),
      .i_imm     (in_if.in_imm),
      .o_word    (w_word),
      .o_illegal (w_illegal)
   );

   assign w_accept = in_if.in_valid & r_ready;
   assign w_write  = w_accept & ~w_illegal;
   assign w_full   = (r_ptr == PTR_MAX);
   assign w_end    = w_accept & (in_if.in_last | (w_write & w_full));
   assign w_start  = start & (r_state != ST_LOAD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // LOAD with ready low is the single drain cycle in which the final write issues.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (start)    w_next = ST_LOAD;
         ST_LOAD:          if (!r_ready) w_next = ST_DONE;
         default:                        w_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ready <= 1'b0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_ptr   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_count <= '0;
      end else begin
         r_we <= w_write;
         if (w_start) begin
            r_ready <= 1'b1;
            r_err   <= 1'b0;
            r_ptr   <= '0;
            r_count <= '0;
         end else begin
            if (w_end) r_ready <= 1'b0;
            if (w_write) begin
               r_addr  <= r_ptr;
               r_wdata <= w_word;
               r_count <= r_count + 1'b1;
               if (!w_full) r_ptr <= r_ptr + 1'b1;
            end
            if ((w_accept & w_illegal) | (w_write & w_full & ~in_if.in_last)) r_err <= 1'b1;
         end
      end
   end

   assign in_if.in_ready = r_ready;
   assign imem_we        = r_we;
   assign imem_addr      = r_addr;
   assign imem_wdata     = r_wdata;
   assign cpu_hold       = (r_state != ST_DONE);
   assign done           = (r_state == ST_DONE);
   assign err            = r_err;
   assign count          = r_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed sessions with literal
// expectations plus a randomized stream compared against a transaction-level model.
module tb_instr_encoder_loader;

   localparam int AW    = 6;
   localparam int DEPTH = 1 << AW;
   localparam int FUNCT_TAB [6] = '{32, 34, 36, 37, 38, 39};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_hold, done, err;
   logic [AW:0]   count;

   instr_encoder_loader_if bus ();

   instr_encoder_loader #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_if      (bus),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err),
      .count      (count)
   );

   initial forever #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoding built from the numeric opcode/funct values.
   function automatic logic [31:0] ref_encode(int op, int rs, int rt, int rd, int imm);
      int opc;
      if (op < 6)
         return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(FUNCT_TAB[op]);
      opc = (op == 6) ? 8 : (op == 7) ? 35 : 43;
      return (32'(opc) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
   endfunction

   // Session-level model: accepting / closing (write in flight) / released.
   bit          m_accepting = 0;
   bit          m_closing   = 0;
   bit          m_released  = 0;
   bit          m_err       = 0;
   bit          m_we        = 0;
   int          m_next_addr = 0;
   int          m_written   = 0;
   logic [31:0] m_addr      = '0;
   logic [31:0] m_data      = '0;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_accepting = 0; m_closing = 0; m_released = 0; m_err = 0; m_we = 0;
         m_next_addr = 0; m_written = 0;
      end else begin : step
         bit legal, at_end;
         m_we = 0;
         if (m_accepting && bus.in_valid) begin
            legal  = (int'(bus.in_op) <= 8);
            at_end = bus.in_last;
            if (legal) begin
               m_we     = 1;
               m_addr   = 32'(m_next_addr);
               m_data   = ref_encode(int'(bus.in_op), int'(bus.in_rs), int'(bus.in_rt),
                                     int'(bus.in_rd), int'(bus.in_imm));
               m_written++;
               if (m_next_addr == DEPTH - 1) begin
                  at_end = 1;
                  if (!bus.in_last) m_err = 1;
               end else begin
                  m_next_addr++;
               end
            end else begin
               m_err = 1;
            end
            if (at_end) begin
               m_accepting = 0;
               m_closing   = 1;
            end
         end else if (m_closing) begin
            m_closing  = 0;
            m_released = 1;
         end else if (!m_accepting && start) begin
            m_accepting = 1; m_released = 0; m_err = 0;
            m_next_addr = 0; m_written = 0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      check("in_ready", 32'(bus.in_ready), 32'(m_accepting));
      check("imem_we",  32'(imem_we),      32'(m_we));
      check("cpu_hold", 32'(cpu_hold),     32'(!m_released));
      check("done",     32'(done),         32'(m_released));
      check("err",      32'(err),          32'(m_err));
      check("count",    32'(count),        32'(m_written));
      if (m_we) begin
         check("imem_addr",  32'(imem_addr), m_addr);
         check("imem_wdata", imem_wdata,     m_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic beat(int op, int rs, int rt, int rd, int imm, bit last);
      bus.in_valid = 1'b1;
      bus.in_op    = 4'(op);
      bus.in_rs    = 5'(rs);
      bus.in_rt    = 5'(rt);
      bus.in_rd    = 5'(rd);
      bus.in_imm   = 16'(imm);
      bus.in_last  = last;
   endtask

   task automatic begin_session();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int pulses;
      logic [31:0] last_addr;
      bus.in_valid = 1'b0;
      bus.in_op    = '0;
      bus.in_rs    = '0;
      bus.in_rt    = '0;
      bus.in_rd    = '0;
      bus.in_imm   = '0;
      bus.in_last  = 1'b0;

      // Reset values
      tick(); tick();
      check("rst_we",     32'(imem_we),    32'd0);
      check("rst_addr",   32'(imem_addr),  32'd0);
      check("rst_wdata",  imem_wdata,      32'd0);
      check("rst_hold",   32'(cpu_hold),   32'd1);
      check("rst_done",   32'(done),       32'd0);
      check("rst_err",    32'(err),        32'd0);
      check("rst_count",  32'(count),      32'd0);
      check("rst_ready",  32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      tick();

      // Single ADD
      begin_session();
      beat(0, 1, 2, 3, 16'hFFFF, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      check("add_we",    32'(imem_we),   32'd1);
      check("add_addr",  32'(imem_addr), 32'd0);
      check("add_data",  imem_wdata,     32'h00221820);
      check("add_count", 32'(count),     32'd1);
      tick();
      check("add_done",  32'(done),      32'd1);

      // Reload from DONE, back-to-back ADDI/LW/SW
      begin_session();
      check("reload_hold", 32'(cpu_hold), 32'd1);
      check("reload_done", 32'(done),     32'd0);
      beat(6, 0, 1, 0, 5, 1'b0);
      tick();
      check("b2b_addr0", 32'(imem_addr), 32'd0);
      check("b2b_data0", imem_wdata,     32'h20010005);
      beat(7, 1, 2, 0, 4, 1'b0);
      tick();
      check("b2b_we1",   32'(imem_we),   32'd1);
      check("b2b_addr1", 32'(imem_addr), 32'd1);
      check("b2b_data1", imem_wdata,     32'h8C220004);
      beat(8, 1, 2, 0, 8, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      check("b2b_addr2", 32'(imem_addr), 32'd2);
      check("b2b_data2", imem_wdata,     32'hAC220008);
      check("b2b_drain_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("b2b_done",  32'(done),      32'd1);
      check("b2b_hold",  32'(cpu_hold),  32'd0);
      check("b2b_count", 32'(count),     32'd3);
      check("b2b_we_off", 32'(imem_we),  32'd0);

      // Illegal op between two legal ops
      begin_session();
      beat(0, 4, 5, 6, 0, 1'b0);
      tick();
      beat(12, 1, 1, 1, 1, 1'b0);
      tick();
      check("ill_we",  32'(imem_we), 32'd0);
      check("ill_err", 32'(err),     32'd1);
      beat(3, 7, 8, 9, 0, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      check("ill_addr", 32'(imem_addr), 32'd1);
      check("ill_data", imem_wdata,     32'h00E84825);
      tick();
      check("ill_done", 32'(done), 32'd1);
      check("ill_err_held", 32'(err), 32'd1);

      // Memory full: more legal beats than words, none marked last
      begin_session();
      check("full_err_cleared", 32'(err), 32'd0);
      pulses = 0;
      last_addr = '0;
      for (int i = 0; i < DEPTH + 6; i++) begin
         beat(6, i % 32, (i + 1) % 32, 0, i, 1'b0);
         tick();
         if (imem_we) begin
            pulses++;
            last_addr = 32'(imem_addr);
         end
      end
      bus.in_valid = 1'b0;
      check("full_pulses", 32'(pulses), 32'(DEPTH));
      check("full_last",   last_addr,   32'(DEPTH - 1));
      check("full_count",  32'(count),  32'(DEPTH));
      check("full_err",    32'(err),    32'd1);
      check("full_done",   32'(done),   32'd1);
      check("full_ready",  32'(bus.in_ready), 32'd0);

      // Reset in the cycle after the second beat is accepted
      begin_session();
      beat(1, 2, 3, 4, 0, 1'b0);
      tick();
      beat(2, 3, 4, 5, 0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("mid_rst_we",    32'(imem_we),   32'd0);
      check("mid_rst_hold",  32'(cpu_hold),  32'd1);
      check("mid_rst_count", 32'(count),     32'd0);
      check("mid_rst_addr",  32'(imem_addr), 32'd0);
      check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      begin_session();
      beat(5, 9, 10, 11, 0, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      check("post_rst_addr", 32'(imem_addr), 32'd0);
      check("post_rst_err",  32'(err),       32'd0);
      check("post_rst_data", imem_wdata,     32'h012A5827);
      tick();

      // Randomized stream, start pulses land in every state
      for (int i = 0; i < 4000; i++) begin
         start        = ($urandom_range(0, 9) == 0);
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.in_op    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                                     : 4'($urandom_range(0, 8));
         bus.in_rs    = 5'($urandom);
         bus.in_rt    = 5'($urandom);
         bus.in_rd    = 5'($urandom);
         bus.in_imm   = 16'($urandom);
         bus.in_last  = ($urandom_range(0, 11) == 0);
         tick();
      end
      start        = 1'b0;
      bus.in_valid = 1'b0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential instruction encoder and program loader for the single-cycle MIPS core: the encode-side counterpart of the core's control decode. It accepts mnemonic-level instruction fields over a valid/ready stream, encodes each into a 32-bit MIPS word using the same opcode and funct values the core decodes, and writes the words to consecutive instruction-memory addresses. While loading, it holds the CPU in reset and releases it when the program is complete.

## Interface
Parameters:
- ADDR_WIDTH, 6, instruction-memory word-address width (64 words).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  begin a load session; sampled in IDLE and DONE only.
- in_valid  in  1  an instruction beat is present.
- in_ready  out  1  the block can accept a beat.
- in_op  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 ADDI, 7 LW, 8 SW; values 9–15 are illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate field; ignored for R-type operations.
- in_last  in  1  marks the final beat of the program.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  32  encoded instruction word.
- cpu_hold  out  1  holds the CPU in reset while high.
- done  out  1  high while in the DONE state.
- err  out  1  sticky error flag; cleared at the start of each session.
- count  out  ADDR_WIDTH+1  number of words written in the current session.

## Operation
- States are IDLE, LOAD and DONE. Reset forces IDLE.
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, err=0, count=0, and the write pointer is 0.
- IDLE → LOAD when start=1. On this transition the pointer, count and err are cleared.
- LOAD: in_ready=1. A beat is accepted when in_valid and in_ready are both high.
- Encoding for R-type operations: {6'b000000, rs, rt, rd, 5'b00000, funct}. The funct values are ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111.
- Encoding for I-type operations: {opcode, rs, rt, imm}. The opcodes are ADDI 001000, LW 100011, SW 101011.
- Legal beat: write the encoded word at the pointer, then increment the pointer and count.
- Illegal in_op: no write occurs, the pointer is not advanced, and err is set. The session continues.
- After an accepted beat with in_last=1, transition to DONE once that beat's write has issued.
- Memory full: if a legal write lands at the address 2^ADDR_WIDTH−1 and in_last=0, then err is set, the state moves to DONE, and in_ready drops in the following cycle. The pointer never wraps.
- An illegal beat with in_last=1 still ends the session and moves to DONE.
- DONE: cpu_hold=0, done=1, in_ready=0. A start pulse here re-enters LOAD with cpu_hold=1 on the next cycle.
- start is ignored while in LOAD.

## Timing
- Encode latency is one cycle. For a beat accepted at edge N, imem_we, imem_addr and imem_wdata are registered and valid for exactly the cycle after edge N.
- Back-to-back beats sustain one write per cycle, with no bubbles.
- imem_we is a single-cycle pulse for each legal beat.
- The transition to DONE takes effect at the edge after the final write pulse. cpu_hold falls and done rises on the same edge.
- Asserting rst mid-session forces all outputs to their reset values immediately and asynchronously. Any pending write is dropped.

## Structure
- Shared package `mips_isa_pkg` holds:
  - the opcode constants (RTYPE, ADDI, LW, SW);
  - the funct constants (ADD, SUB, AND, OR, XOR, NOR);
  - the 4-bit in_op code list.
- The core's control decode and this block both use `mips_isa_pkg`.
- One combinational sub-module, `instr_encode`, maps {op, rs, rt, rd, imm} to {word, illegal}.
- The FSM, the pointer and the output registers live in the top module.

## Test plan
- Encoding check: start, then ADD rd=3 rs=1 rt=2 → imem_we pulse with addr 0 and data 0x00221820; count=1.
- Back-to-back stream: ADDI rt=1 rs=0 imm=5, LW rt=2 rs=1 imm=4, SW rt=2 rs=1 imm=8 (last), with valid held high → writes 0x20010005, 0x8C220004 and 0xAC220008 at addresses 0–2 on consecutive cycles; done=1 and cpu_hold=0 on the edge after the third write; count=3.
- Illegal op: in_op=12 between two legal ops → no write for that beat, the second legal op lands at address 1, err=1, and the session still completes.
- Memory full: ADDR_WIDTH=2, five legal beats with no in_last → four writes at addresses 0–3; after the fourth write, err=1, DONE is entered, in_ready=0, and the fifth beat is never accepted.
- Reset mid-session: assert rst in the cycle after acceptance of the second beat → imem_we=0 immediately, state IDLE, cpu_hold=1, count=0; a new start reloads from address 0 with err=0.
- Reload: in DONE, pulse start → cpu_hold=1 and done=0 on the next cycle, and the pointer restarts at address 0.
